output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Wormhole packet arbiter and output multiplexer for one router output port. It sits directly downstream of the flow-control stage and consumes that stage's per-input ready signals, which are qualified by port selection and output-FIFO space, as requests. It grants one input at a time in round-robin order, locks the grant from head flit to tail flit, and forwards one flit per cycle into the output FIFO through a registered output stage. Each router instantiates five copies, one per output direction.

## Interface
- DATA_WIDTH, default 32, flit width in bits.
- STALL_LIMIT, default 255, number of consecutive locked cycles without a transfer before a stall is flagged. Used only with OUTARB_STALL_DET_EN.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  5  per-input request, index 0..4 = L,N,E,W,S. Driven by the flow-control ready outputs for this output port.
- tail  input  5  per-input flag: the head-of-FIFO flit of that input is a tail. A single-flit packet has its head also marked tail.
- flit_in  input  5*DATA_WIDTH  head-of-FIFO flits; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_ready  input  1  output FIFO guarantees one free slot at the next edge.
- grant  output  5  one-hot pop strobe to the input FIFOs, asserted only in the cycle a flit is transferred. Combinational.
- flit_out  output  DATA_WIDTH  registered forwarded flit.
- flit_valid  output  1  registered write strobe to the output FIFO.
- stall_err  output  1  sticky stall flag.

## Operation
- FSM has two states, IDLE and LOCKED. A 3-bit owner register holds values 0..4. A 3-bit round-robin pointer ptr holds values 0..4.
- **IDLE.** Search req starting at index ptr, then ptr+1, and so on, modulo 5. The first set bit becomes the owner, and the next state is LOCKED. No flit transfers in IDLE. If req is all zero, stay in IDLE.
- **LOCKED, transfer condition.** transfer = req[owner] && out_ready.
  - When transfer is high, grant = 1<<owner, and flit_in slice [owner] is registered to flit_out with flit_valid=1 at the next edge.
  - If tail[owner] is set during a transfer, the next state is IDLE and ptr = (owner+1) mod 5.
- **LOCKED, no transfer.** If req[owner] is low or out_ready is low, grant=0 and the FSM stays LOCKED. Requests from other inputs are ignored while locked, including a packet body in flight.
- **flit_valid.** Deasserts in any cycle following a non-transfer cycle. flit_out holds its last value when no transfer occurs.
- **Grant outside LOCKED.** grant is never asserted in IDLE or during rst.
- **Reset.** rst in any state has the following effect at the next edge:
  - FSM goes to IDLE, ptr=0, owner=0.
  - flit_out=0, flit_valid=0, stall_err=0.
  - A packet interrupted mid-transfer is abandoned. Input FIFOs are reset by the same rst.

## Timing
- **Reset values:** grant=0, flit_out=0, flit_valid=0, stall_err=0.
- **Arbitration latency:** a request seen in IDLE at cycle t gives LOCKED at t+1. The first grant can occur at t+1.
- **Data latency:** a grant in cycle t produces flit_valid/flit_out at t+1.
- **Throughput:** one flit per cycle while locked and unblocked.
- **Packet turnaround:** a tail transfer at cycle t returns the FSM to IDLE at t+1. The next packet's first flit is granted at t+2, so there is one bubble between packets.
- **Single-flit packet:** IDLE(t), grant(t+1), IDLE(t+2).
- **Simultaneous requests in IDLE:** the pointer order decides. After reset the priority order is L,N,E,W,S.

## Configuration
- **OUTARB_STALL_DET_EN defined:**
  - An 8-bit saturating counter increments every LOCKED cycle without a transfer.
  - The counter clears on any transfer and in IDLE.
  - When the counter reaches STALL_LIMIT, stall_err sets and stays set until rst.
- **OUTARB_STALL_DET_EN undefined:** no counter is built and stall_err is tied to 0.

## Test plan
- **Reset:** hold rst 2 cycles with req=5'b11111 → grant=0, flit_valid=0, flit_out=0. After release, the first lock is on L (owner 0).
- **3-flit packet on E:** req=5'b00100, out_ready=1, tail on the third flit, flits 0xA1/0xA2/0xA3 → grant=5'b00100 for 3 consecutive cycles, flit_out 0xA1,0xA2,0xA3 each one cycle later, then IDLE.
- **Round-robin fairness:** L and S both continuously send single-flit packets → grants alternate 00001, 10000, 00001, … with ptr wrap from 4 to 0 verified.
- **Backpressure mid-packet:** drop out_ready for 3 cycles during an N packet while W requests → no grant, flit_valid=0, W never granted until N's tail is sent.
- **Reset mid-packet:** assert rst after the 2nd of 4 flits → next cycle IDLE, flit_valid=0, ptr=0.
- **Stall detection:** with OUTARB_STALL_DET_EN defined and STALL_LIMIT=10, lock on N then hold out_ready=0 → stall_err rises after the 10th stalled cycle and stays high. With the macro undefined, stall_err stays 0.

Source files
------------

// File: rtl/output_port_arbiter.sv
// output_port_arbiter
//   Wormhole arbiter and output mux for one router output port. Picks one
//   requesting input in round-robin order, holds it from head flit to tail
//   flit, and forwards one flit per cycle into the output FIFO through a
//   registered stage.
//
//   Optional feature macro: OUTARB_STALL_DET_EN
//     defined   - 8-bit saturating stall counter; stall_err is set when
//                 STALL_LIMIT consecutive blocked LOCKED cycles are seen.
//     undefined - no counter; stall_err is tied to 0.
//
//   Ports
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     req[4:0]   per-input request (0..4 = L,N,E,W,S)
//     tail[4:0]  per-input "head-of-FIFO flit is a tail"
//     flit_in    five head-of-FIFO flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//     out_ready  output FIFO has a free slot at the next edge
//     grant      one-hot pop strobe, combinational, only on a transfer
//     flit_out   registered forwarded flit
//     flit_valid registered write strobe to the output FIFO
//     stall_err  sticky stall flag
//
//   state  | meaning
//   IDLE   | no owner; searching req from ptr for the next packet
//   LOCKED | owner holds the port until its tail flit is transferred
module output_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              req,
  input  logic [4:0]              tail,
  input  logic [5*DATA_WIDTH-1:0] flit_in,
  input  logic                    out_ready,
  output logic [4:0]              grant,
  output logic [DATA_WIDTH-1:0]   flit_out,
  output logic                    flit_valid,
  output logic                    stall_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state;
  logic [2:0]            owner;
  logic [2:0]            ptr;
  logic                  transfer;
  logic                  found;
  logic [2:0]            pick;
  logic [3:0]            sum;
  logic [DATA_WIDTH-1:0] sel_flit;

  // Round-robin search starting at ptr, wrapping modulo 5.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    sum   = 4'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum > 4'd4) sum = sum - 4'd5;
      if (!found && req[sum[2:0]]) begin
        found = 1'b1;
        pick  = sum[2:0];
      end
    end
  end

  // rst gating keeps grant quiet during reset regardless of stale state.
  assign transfer = !rst && (state == ST_LOCKED) && req[owner] && out_ready;

  always_comb begin
    grant    = 5'b0;
    sel_flit = '0;
    for (int i = 0; i < 5; i++) begin
      if (owner == 3'(i)) begin
        grant[i] = transfer;
        sel_flit = flit_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 3'd0;
      ptr        <= 3'd0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
    end else begin
      flit_valid <= transfer;
      if (transfer) flit_out <= sel_flit;
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner <= pick;
            state <= ST_LOCKED;
          end
        end
        default: begin
          if (transfer && tail[owner]) begin
            state <= ST_IDLE;
            ptr   <= (owner == 3'd4) ? 3'd0 : owner + 3'd1;
          end
        end
      endcase
    end
  end

`ifdef OUTARB_STALL_DET_EN
  logic [7:0] stall_cnt;
  logic       stall_err_q;

  // stall_err sets on the same edge at which the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= 8'd0;
      stall_err_q <= 1'b0;
    end else if (state == ST_LOCKED && !transfer) begin
      if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
      if (({1'b0, stall_cnt} + 9'd1) >= 9'(STALL_LIMIT)) stall_err_q <= 1'b1;
    end else begin
      stall_cnt <= 8'd0;
    end
  end

  assign stall_err = stall_err_q;
`else
  logic unused_stall_limit;
  assign unused_stall_limit = (STALL_LIMIT == 0);
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;

`ifdef OUTARB_STALL_DET_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  req;
  logic [4:0]  tail;
  logic [7:0]  fl [5];
  logic [39:0] flit_in;
  logic        out_ready;
  logic [4:0]  grant;
  logic [7:0]  flit_out;
  logic        flit_valid;
  logic        stall_err;

  int tests;
  int fails;

  assign flit_in = {fl[4], fl[3], fl[2], fl[1], fl[0]};

  output_port_arbiter #(.DATA_WIDTH(8), .STALL_LIMIT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .flit_in(flit_in),
    .out_ready(out_ready), .grant(grant), .flit_out(flit_out),
    .flit_valid(flit_valid), .stall_err(stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after input changes
  task automatic settle();
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; req = 5'b11111; tail = 5'b11111; out_ready = 1'b1;
    fl[0] = 8'h10; fl[1] = 8'h20; fl[2] = 8'h30; fl[3] = 8'h40; fl[4] = 8'h50;

    // reset held two cycles with all inputs requesting
    cyc(); cyc();
    settle();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(flit_valid), 32'h0);
    chk("rst_flit", 32'(flit_out), 32'h0);
    chk("rst_stall", 32'(stall_err), 32'h0);
    rst = 1'b0;
    settle();
    chk("idle_no_grant", 32'(grant), 32'h0);
    cyc(); settle();
    chk("first_lock_L", 32'(grant), 32'h01);
    cyc(); req = 5'b0; settle();
    chk("first_flit_L", 32'(flit_out), 32'h10);
    chk("first_valid", 32'(flit_valid), 32'h1);
    cyc(); settle();
    chk("valid_drop", 32'(flit_valid), 32'h0);

    // 3-flit packet on E (ptr now 1)
    req = 5'b00100; tail = 5'b00000; fl[2] = 8'hA1; settle();
    chk("e_idle", 32'(grant), 32'h0);
    cyc(); settle();
    chk("e_g1", 32'(grant), 32'h04);
    cyc(); fl[2] = 8'hA2; settle();
    chk("e_g2", 32'(grant), 32'h04);
    chk("e_f1", 32'(flit_out), 32'hA1);
    chk("e_v1", 32'(flit_valid), 32'h1);
    cyc(); fl[2] = 8'hA3; tail = 5'b00100; settle();
    chk("e_g3", 32'(grant), 32'h04);
    chk("e_f2", 32'(flit_out), 32'hA2);
    cyc(); req = 5'b0; tail = 5'b0; settle();
    chk("e_idle_after", 32'(grant), 32'h0);
    chk("e_f3", 32'(flit_out), 32'hA3);
    chk("e_v3", 32'(flit_valid), 32'h1);
    cyc(); settle();
    chk("e_hold_flit", 32'(flit_out), 32'hA3);
    chk("e_hold_valid", 32'(flit_valid), 32'h0);

    // round robin L vs S, single-flit packets; ptr=3 so S wins first
    req = 5'b10001; tail = 5'b11111; fl[0] = 8'h11; fl[4] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_idle", 32'(grant), 32'h0);
      if (i > 0) chk("rr_flit", 32'(flit_out), (i % 2 == 1) ? 32'h55 : 32'h11);
      cyc(); settle();
      chk("rr_grant", 32'(grant), (i % 2 == 0) ? 32'h10 : 32'h01);
      cyc();
    end
    req = 5'b0; settle();
    chk("rr_last_flit", 32'(flit_out), 32'h11);

    // backpressure on N packet while W requests (ptr now 1)
    cyc();
    req = 5'b01010; tail = 5'b00000; fl[1] = 8'hB1; fl[3] = 8'hC7; settle();
    chk("bp_idle", 32'(grant), 32'h0);
    cyc(); settle();
    chk("bp_g1", 32'(grant), 32'h02);
    cyc(); fl[1] = 8'hB2; out_ready = 1'b0; settle();
    chk("bp_blk1", 32'(grant), 32'h0);
    chk("bp_v1", 32'(flit_valid), 32'h1);
    chk("bp_f1", 32'(flit_out), 32'hB1);
    cyc(); settle();
    chk("bp_blk2", 32'(grant), 32'h0);
    chk("bp_v_blk2", 32'(flit_valid), 32'h0);
    cyc(); settle();
    chk("bp_blk3", 32'(grant), 32'h0);
    chk("bp_v_blk3", 32'(flit_valid), 32'h0);
    chk("bp_f_hold", 32'(flit_out), 32'hB1);
    cyc(); out_ready = 1'b1; settle();
    chk("bp_g2", 32'(grant), 32'h02);
    cyc(); fl[1] = 8'hB3; tail = 5'b01010; settle();
    chk("bp_g3", 32'(grant), 32'h02);
    chk("bp_f2", 32'(flit_out), 32'hB2);
    cyc(); settle();
    chk("bp_idle2", 32'(grant), 32'h0);
    chk("bp_f3", 32'(flit_out), 32'hB3);
    cyc(); settle();
    chk("bp_w_grant", 32'(grant), 32'h08);
    cyc(); req = 5'b0; tail = 5'b0; settle();
    chk("bp_w_flit", 32'(flit_out), 32'hC7);

    // reset mid-packet: 4-flit N packet (ptr now 4), reset after flit 2
    cyc();
    req = 5'b00010; fl[1] = 8'hD1; settle();
    cyc(); settle();
    chk("rm_g1", 32'(grant), 32'h02);
    cyc(); fl[1] = 8'hD2; settle();
    chk("rm_g2", 32'(grant), 32'h02);
    cyc(); rst = 1'b1; fl[1] = 8'hD3; settle();
    chk("rm_rst_grant", 32'(grant), 32'h0);
    chk("rm_f2", 32'(flit_out), 32'hD2);
    cyc(); rst = 1'b0; req = 5'b10011; tail = 5'b11111; settle();
    chk("rm_idle", 32'(grant), 32'h0);
    chk("rm_valid", 32'(flit_valid), 32'h0);
    chk("rm_flit", 32'(flit_out), 32'h0);
    cyc(); settle();
    chk("rm_ptr0_L", 32'(grant), 32'h01);
    cyc(); req = 5'b0; tail = 5'b0; settle();

    // stall detection: lock on N (ptr now 1), then block output
    cyc();
    req = 5'b00010; out_ready = 1'b0; settle();
    cyc();
    for (int i = 0; i < 9; i++) cyc();
    settle();
    chk("stall_before", 32'(stall_err), 32'h0);
    chk("stall_no_grant", 32'(grant), 32'h0);
    cyc(); settle();
    chk("stall_set", 32'(stall_err), 32'(STALL_EN));
    out_ready = 1'b1; tail = 5'b00010; settle();
    chk("stall_release", 32'(grant), 32'h02);
    cyc(); req = 5'b0; tail = 5'b0; settle();
    chk("stall_sticky", 32'(stall_err), 32'(STALL_EN));
    chk("stall_flit", 32'(flit_out), 32'hD3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
